alu_exec_unit: RTL and testbench

Parametrised execute-stage ALU for the pipelined datapath. It folds ALU-control decode (aluOp/func into an internal operation code) together with the arithmetic itself. It adds an iterative multiply/divide engine with HI/LO registers and a valid/ready handshake toward the ID/EX stage. Single-cycle operations are registered with 1-cycle latency; MULT/MULTU/DIV/DIVU are multi-cycle and backpressure the pipeline.

---
 rtl/alu_pkg.sv | 91 +++++++++
 rtl/alu_muldiv.sv | 125 ++++++++++++
 rtl/alu_exec_unit.sv | 141 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the execute-stage ALU.
//   - alu_op encodings coming from the main decoder
//   - R-type func field constants
//   - 5-bit internal operation codes reported on o_alu_ctrl
//   - FSM state enum and the ALU-control decode function
package alu_pkg;

  // alu_op from the main decoder
  localparam logic [1:0] AOP_RTYPE = 2'b00;
  localparam logic [1:0] AOP_ADD   = 2'b01;
  localparam logic [1:0] AOP_SUB   = 2'b10;
  localparam logic [1:0] AOP_SLT   = 2'b11;

  // internal operation codes
  localparam logic [4:0] OP_ADD     = 5'b00000;
  localparam logic [4:0] OP_SUB     = 5'b00001;
  localparam logic [4:0] OP_AND     = 5'b00010;
  localparam logic [4:0] OP_NOR     = 5'b00011;
  localparam logic [4:0] OP_OR      = 5'b00100;
  localparam logic [4:0] OP_SLT     = 5'b00101;
  localparam logic [4:0] OP_XOR     = 5'b00110;
  localparam logic [4:0] OP_SLL     = 5'b00111;
  localparam logic [4:0] OP_SRL     = 5'b01000;
  localparam logic [4:0] OP_SRA     = 5'b01001;
  localparam logic [4:0] OP_SLTU    = 5'b01010;
  localparam logic [4:0] OP_MULT    = 5'b01011;
  localparam logic [4:0] OP_MULTU   = 5'b01100;
  localparam logic [4:0] OP_DIV     = 5'b01101;
  localparam logic [4:0] OP_DIVU    = 5'b01110;
  localparam logic [4:0] OP_MFHI    = 5'b01111;
  localparam logic [4:0] OP_MFLO    = 5'b10000;
  localparam logic [4:0] OP_ILLEGAL = 5'b11111;

  // R-type func field
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  // ALU-control decode; total over all inputs.
  function automatic logic [4:0] decode_op(input logic [1:0] alu_op, input logic [5:0] func);
    logic [4:0] op;
    op = OP_ILLEGAL;
    case (alu_op)
      AOP_ADD: op = OP_ADD;
      AOP_SUB: op = OP_SUB;
      AOP_SLT: op = OP_SLT;
      default: begin
        case (func)
          FN_ADD, FN_ADDU: op = OP_ADD;
          FN_SUB, FN_SUBU: op = OP_SUB;
          FN_AND:          op = OP_AND;
          FN_NOR:          op = OP_NOR;
          FN_OR:           op = OP_OR;
          FN_SLT:          op = OP_SLT;
          FN_XOR:          op = OP_XOR;
          FN_SLL:          op = OP_SLL;
          FN_SRL:          op = OP_SRL;
          FN_SRA:          op = OP_SRA;
          FN_SLTU:         op = OP_SLTU;
          FN_MULT:         op = OP_MULT;
          FN_MULTU:        op = OP_MULTU;
          FN_DIV:          op = OP_DIV;
          FN_DIVU:         op = OP_DIVU;
          FN_MFHI:         op = OP_MFHI;
          FN_MFLO:         op = OP_MFLO;
          default:         op = OP_ILLEGAL;
        endcase
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply / divide engine, one iteration per cycle,
// WIDTH iterations per operation.
//   i_start   load operands and begin (ignored while i_abort)
//   i_abort   discard in-flight operation
//   i_is_div  divide (1) or multiply (0); i_signed selects signed variant
//   i_opa/b   operands (a = multiplicand / dividend, b = multiplier / divisor)
//   o_last    final iteration happens at the coming edge
//   o_done    one-cycle flag: o_hi_next/o_lo_next hold the final result
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_is_div,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  output logic             o_last,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi_next,
  output logic [WIDTH-1:0] o_lo_next
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      r_cnt;
  logic               r_run, r_done, r_is_div, r_neg_q, r_neg_r, r_dz;
  logic [2*WIDTH-1:0] r_acc;    // product (mul) / partial remainder in low bits (div)
  logic [2*WIDTH-1:0] r_mcand;  // shifted multiplicand (mul) / divisor in low half (div)
  logic [WIDTH-1:0]   r_q;      // multiplier shifting out (mul) / dividend->quotient (div)
  logic [WIDTH-1:0]   r_opa;    // kept for the divide-by-zero result

  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_rem_sh, w_dvs, w_sub, w_rem_nx;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot, w_rem;

  assign w_a_neg = i_signed & i_opa[WIDTH-1];
  assign w_b_neg = i_signed & i_opb[WIDTH-1];
  assign w_a_mag = w_a_neg ? -i_opa : i_opa;
  assign w_b_mag = w_b_neg ? -i_opb : i_opb;

  // restoring-division step: shift next dividend bit in, subtract if it fits
  assign w_rem_sh = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_dvs    = {1'b0, r_mcand[WIDTH-1:0]};
  assign w_ge     = (w_rem_sh >= w_dvs);
  assign w_sub    = w_rem_sh - w_dvs;
  assign w_rem_nx = w_ge ? w_sub : w_rem_sh;

  assign o_last = r_run && (r_cnt == CW'(WIDTH-1));
  assign o_done = r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_q      <= '0;
      r_opa    <= '0;
    end else if (i_abort) begin
      r_run  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_cnt    <= '0;
      r_run    <= 1'b1;
      r_done   <= 1'b0;
      r_is_div <= i_is_div;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_dz     <= i_is_div && (i_opb == '0);
      r_opa    <= i_opa;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, (i_is_div ? w_b_mag : w_a_mag)};
      r_q      <= i_is_div ? w_a_mag : w_b_mag;
    end else if (r_run) begin
      if (r_is_div) begin
        r_acc <= {{(WIDTH-1){1'b0}}, w_rem_nx};
        r_q   <= {r_q[WIDTH-2:0], w_ge};
      end else begin
        if (r_q[0]) r_acc <= r_acc + r_mcand;
        r_mcand <= r_mcand << 1;
        r_q     <= r_q >> 1;
      end
      r_cnt <= r_cnt + 1'b1;
      if (o_last) begin
        r_run  <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  // sign fix-up on the magnitude results
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quot = r_neg_q ? -r_q : r_q;
  assign w_rem  = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

  always_comb begin
    o_hi_next = w_prod[2*WIDTH-1:WIDTH];
    o_lo_next = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_dz) begin
        o_hi_next = r_opa;
        o_lo_next = '1;
      end else begin
        o_hi_next = w_rem;
        o_lo_next = w_quot;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with ALU-control decode, single-cycle
// datapath, iterative mul/div (alu_muldiv) and architectural HI/LO.
//   i_in_valid/o_in_ready  op handshake (ready only in IDLE)
//   i_flush                squash incoming / in-flight op
//   i_alu_op, i_func       operation select; i_opa/i_opb/i_shamt operands
//   o_out_valid            1-cycle pulse per completed op
//   o_result, o_zero       registered result and (result == 0), held between pulses
//   o_alu_ctrl, o_illegal  op code of completed op, undefined-func flag
//   o_hi, o_lo             HI/LO registers
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_flush,
  input  logic [1:0]       i_alu_op,
  input  logic [5:0]       i_func,
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  input  logic [SHW-1:0]   i_shamt,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic [4:0]       o_alu_ctrl,
  output logic             o_illegal,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  state_e           r_state;
  logic             r_out_valid, r_zero, r_illegal;
  logic [WIDTH-1:0] r_result, r_hi, r_lo;
  logic [4:0]       r_alu_ctrl, r_pend_ctrl;

  logic [4:0]       w_ctrl;
  logic             w_is_md, w_accept, w_md_last, w_md_done;
  logic [WIDTH-1:0] w_sc_res, w_hi_next, w_lo_next;

  assign w_ctrl   = decode_op(i_alu_op, i_func);
  assign w_is_md  = (w_ctrl == OP_MULT) || (w_ctrl == OP_MULTU) ||
                    (w_ctrl == OP_DIV)  || (w_ctrl == OP_DIVU);
  assign w_accept = (r_state == ST_IDLE) && i_in_valid && !i_flush;

  always_comb begin
    w_sc_res = '0;
    case (w_ctrl)
      OP_ADD:  w_sc_res = i_opa + i_opb;
      OP_SUB:  w_sc_res = i_opa - i_opb;
      OP_AND:  w_sc_res = i_opa & i_opb;
      OP_NOR:  w_sc_res = ~(i_opa | i_opb);
      OP_OR:   w_sc_res = i_opa | i_opb;
      OP_XOR:  w_sc_res = i_opa ^ i_opb;
      OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(i_opa) < $signed(i_opb))};
      OP_SLTU: w_sc_res = {{(WIDTH-1){1'b0}}, (i_opa < i_opb)};
      OP_SLL:  w_sc_res = i_opb << i_shamt;
      OP_SRL:  w_sc_res = i_opb >> i_shamt;
      OP_SRA:  w_sc_res = $unsigned($signed(i_opb) >>> i_shamt);
      OP_MFHI: w_sc_res = r_hi;
      OP_MFLO: w_sc_res = r_lo;
      default: w_sc_res = '0;  // ILLEGAL (mul/div never take this path)
    endcase
  end

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (w_accept && w_is_md),
    .i_abort   (i_flush && (r_state != ST_IDLE)),
    .i_is_div  ((w_ctrl == OP_DIV) || (w_ctrl == OP_DIVU)),
    .i_signed  ((w_ctrl == OP_MULT) || (w_ctrl == OP_DIV)),
    .i_opa     (i_opa),
    .i_opb     (i_opb),
    .o_last    (w_md_last),
    .o_done    (w_md_done),
    .o_hi_next (w_hi_next),
    .o_lo_next (w_lo_next)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_alu_ctrl  <= '0;
      r_illegal   <= 1'b0;
      r_pend_ctrl <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_md) begin
              r_state     <= ST_BUSY;
              r_pend_ctrl <= w_ctrl;
            end else begin
              r_out_valid <= 1'b1;
              r_result    <= w_sc_res;
              r_zero      <= (w_sc_res == '0);
              r_alu_ctrl  <= w_ctrl;
              r_illegal   <= (w_ctrl == OP_ILLEGAL);
            end
          end
        end
        ST_BUSY: begin
          if (i_flush)        r_state <= ST_IDLE;
          else if (w_md_last) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          if (!i_flush && w_md_done) begin
            r_hi        <= w_hi_next;
            r_lo        <= w_lo_next;
            r_out_valid <= 1'b1;
            r_result    <= w_lo_next;
            r_zero      <= (w_lo_next == '0);
            r_alu_ctrl  <= r_pend_ctrl;
            r_illegal   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == ST_IDLE);
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_zero      = r_zero;
  assign o_alu_ctrl  = r_alu_ctrl;
  assign o_illegal   = r_illegal;
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   alu_op = 2'b00;
  logic [5:0]   func = 6'b0;
  logic [W-1:0] opa = '0, opb = '0;
  logic [4:0]   shamt = '0;
  logic         in_ready, out_valid, zero, illegal;
  logic [W-1:0] result, hi, lo;
  logic [4:0]   alu_ctrl;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_flush(flush), .i_alu_op(alu_op), .i_func(func), .i_opa(opa), .i_opb(opb),
    .i_shamt(shamt), .o_out_valid(out_valid), .o_result(result), .o_zero(zero),
    .o_alu_ctrl(alu_ctrl), .o_illegal(illegal), .o_hi(hi), .o_lo(lo)
  );

  // present one op for one accept edge; returns #1 after that edge
  task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] sh);
    @(negedge clk);
    in_valid = 1'b1; alu_op = op; func = fn; opa = a; opb = b; shamt = sh;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // after drive() of a mul/div: cycles until out_valid (-1 on timeout) and
  // number of samples with in_ready low before it
  task automatic wait_done(output int cyc, output int low);
    cyc = -1; low = 0;
    if (!in_ready) low++;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin cyc = i; break; end
      if (!in_ready) low++;
    end
  endtask

  task automatic test_reset;
    total++; if (result !== 32'h0) begin bad++; $display("FAIL rst_result got=%h exp=0", result); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL rst_zero got=%b exp=1", zero); end
    total++; if ({out_valid, illegal, alu_ctrl} !== 7'b0) begin bad++; $display("FAIL rst_flags got=%b%b%h exp=0", out_valid, illegal, alu_ctrl); end
    total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL rst_hilo got=%h_%h exp=0", hi, lo); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add_sub;
    drive(2'b00, 6'b100000, 32'd5, 32'd7, 5'd0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    total++; if (result !== 32'd12) begin bad++; $display("FAIL add_result got=%h exp=c", result); end
    total++; if ({zero, alu_ctrl} !== 6'b0_00000) begin bad++; $display("FAIL add_zero_ctrl got=%b_%b exp=0_00000", zero, alu_ctrl); end
    drive(2'b00, 6'b100010, 32'd7, 32'd7, 5'd0);
    total++; if ({result, zero} !== {32'h0, 1'b1}) begin bad++; $display("FAIL sub_result got=%h z=%b exp=0 z=1", result, zero); end
    total++; if (alu_ctrl !== 5'b00001) begin bad++; $display("FAIL sub_ctrl got=%b exp=00001", alu_ctrl); end
    @(posedge clk); #1;
    total++; if ({out_valid, result, zero} !== {1'b0, 32'h0, 1'b1}) begin bad++; $display("FAIL hold got=v%b r=%h z=%b exp=v0 r=0 z=1", out_valid, result, zero); end
  endtask

  task automatic test_aluop;
    drive(2'b01, 6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd0);
    total++; if ({result, zero, alu_ctrl} !== {32'h0, 1'b1, 5'b00000}) begin bad++; $display("FAIL aluop01 got=%h z=%b c=%b exp=0 z=1 c=00000", result, zero, alu_ctrl); end
    drive(2'b11, 6'b000000, 32'hFFFF_FFFF, 32'd0, 5'd0);
    total++; if ({result, alu_ctrl} !== {32'd1, 5'b00101}) begin bad++; $display("FAIL aluop11 got=%h c=%b exp=1 c=00101", result, alu_ctrl); end
    drive(2'b10, 6'b100000, 32'd3, 32'd5, 5'd0);
    total++; if (result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL aluop10 got=%h exp=fffffffe", result); end
  endtask

  task automatic test_back_to_back;
    logic [5:0]   fn [4] = '{6'b100100, 6'b100101, 6'b100110, 6'b100111};
    logic [W-1:0] va [4] = '{32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_00FF, 32'h0};
    logic [W-1:0] vb [4] = '{32'h0000_FF00, 32'h0000_0F0F, 32'h0000_000F, 32'h0};
    logic [W-1:0] ex [4] = '{32'h0000_F000, 32'h0000_FFFF, 32'h0000_00F0, 32'hFFFF_FFFF};
    logic [4:0]   ec [4] = '{5'b00010, 5'b00100, 5'b00110, 5'b00011};
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; alu_op = 2'b00; func = fn[i]; opa = va[i]; opb = vb[i];
      @(posedge clk); #1;
      total++;
      if ({out_valid, result, alu_ctrl} !== {1'b1, ex[i], ec[i]}) begin
        bad++; $display("FAIL b2b_%0d got=v%b r=%h c=%b exp=v1 r=%h c=%b", i, out_valid, result, alu_ctrl, ex[i], ec[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_misc;
    drive(2'b00, 6'b111111, 32'd9, 32'd9, 5'd0);
    total++; if ({out_valid, illegal, result, alu_ctrl} !== {1'b1, 1'b1, 32'h0, 5'b11111}) begin bad++; $display("FAIL illegal got=v%b i=%b r=%h c=%b exp=v1 i=1 r=0 c=11111", out_valid, illegal, result, alu_ctrl); end
    drive(2'b00, 6'b000011, 32'h0, 32'h8000_0000, 5'd4);
    total++; if ({illegal, result} !== {1'b0, 32'hF800_0000}) begin bad++; $display("FAIL sra got=i%b %h exp=i0 f8000000", illegal, result); end
    drive(2'b00, 6'b101011, 32'd1, 32'hFFFF_FFFF, 5'd0);
    total++; if (result !== 32'd1) begin bad++; $display("FAIL sltu got=%h exp=1", result); end
    drive(2'b00, 6'b101010, 32'd1, 32'hFFFF_FFFF, 5'd0);
    total++; if (result !== 32'd0) begin bad++; $display("FAIL slt got=%h exp=0", result); end
    drive(2'b00, 6'b000000, 32'h0, 32'd1, 5'd31);
    total++; if (result !== 32'h8000_0000) begin bad++; $display("FAIL sll got=%h exp=80000000", result); end
    drive(2'b00, 6'b000010, 32'h0, 32'h8000_0000, 5'd31);
    total++; if (result !== 32'd1) begin bad++; $display("FAIL srl got=%h exp=1", result); end
  endtask

  task automatic test_mult;
    int cyc, low;
    drive(2'b00, 6'b011000, 32'hFFFF_FFFE, 32'd3, 5'd0);
    wait_done(cyc, low);
    total++; if (cyc != 33) begin bad++; $display("FAIL mult_latency got=%0d exp=33", cyc); end
    total++; if (low != 33) begin bad++; $display("FAIL mult_ready_low got=%0d exp=33", low); end
    total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin bad++; $display("FAIL mult_hilo got=%h_%h exp=ffffffff_fffffffa", hi, lo); end
    total++; if ({result, alu_ctrl, in_ready} !== {32'hFFFF_FFFA, 5'b01011, 1'b1}) begin bad++; $display("FAIL mult_out got=%h c=%b rdy=%b exp=fffffffa c=01011 rdy=1", result, alu_ctrl, in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mult_pulse got=%b exp=0", out_valid); end
    drive(2'b00, 6'b010000, 32'h0, 32'h0, 5'd0);
    total++; if ({out_valid, result} !== {1'b1, 32'hFFFF_FFFF}) begin bad++; $display("FAIL mfhi got=v%b %h exp=v1 ffffffff", out_valid, result); end
    drive(2'b00, 6'b010010, 32'h0, 32'h0, 5'd0);
    total++; if (result !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mflo got=%h exp=fffffffa", result); end
    drive(2'b00, 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    wait_done(cyc, low);
    total++; if ({hi, lo, alu_ctrl} !== {64'hFFFF_FFFE_0000_0001, 5'b01100}) begin bad++; $display("FAIL multu got=%h_%h c=%b exp=fffffffe_00000001 c=01100", hi, lo, alu_ctrl); end
  endtask

  task automatic test_div;
    int cyc, low;
    drive(2'b00, 6'b011011, 32'd7, 32'd0, 5'd0);
    wait_done(cyc, low);
    total++; if (cyc != 33) begin bad++; $display("FAIL divu0_latency got=%0d exp=33", cyc); end
    total++; if ({hi, lo, result} !== {32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin bad++; $display("FAIL divu0 got=%h_%h r=%h exp=7_ffffffff", hi, lo, result); end
    drive(2'b00, 6'b011010, 32'hFFFF_FFF9, 32'd2, 5'd0);
    wait_done(cyc, low);
    total++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin bad++; $display("FAIL div_neg got=%h_%h exp=ffffffff_fffffffd", hi, lo); end
    drive(2'b00, 6'b011011, 32'd100, 32'd7, 5'd0);
    wait_done(cyc, low);
    total++; if ({hi, lo} !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu got=%h_%h exp=2_e", hi, lo); end
    drive(2'b00, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    wait_done(cyc, low);
    total++; if ({hi, lo, zero} !== {32'h0, 32'h8000_0000, 1'b0}) begin bad++; $display("FAIL div_ovf got=%h_%h z=%b exp=0_80000000 z=0", hi, lo, zero); end
  endtask

  task automatic test_flush;
    int seen = 0;
    logic [W-1:0] h0, l0;
    h0 = 32'h0; l0 = 32'h8000_0000;   // left by the last divide
    drive(2'b00, 6'b011010, 32'd100, 32'd7, 5'd0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL flush_busy got=rdy%b v%b exp=rdy1 v0", in_ready, out_valid); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL flush_novalid got=%0d exp=0", seen); end
    total++; if ({hi, lo} !== {h0, l0}) begin bad++; $display("FAIL flush_hilo got=%h_%h exp=%h_%h", hi, lo, h0, l0); end
    // flushed request in IDLE is not accepted
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; alu_op = 2'b01; opa = 32'd1; opb = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL flush_idle got=v%b rdy%b exp=v0 rdy1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid;
    int cyc, low;
    drive(2'b00, 6'b011001, 32'd3, 32'd5, 5'd0);
    wait_done(cyc, low);
    total++; if ({lo, result} !== {32'd15, 32'd15}) begin bad++; $display("FAIL mult_small got=%h r=%h exp=f", lo, result); end
    drive(2'b00, 6'b011000, 32'd6, 32'd7, 5'd0);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({in_ready, out_valid, zero, illegal} !== 4'b1010) begin bad++; $display("FAIL rstmid_flags got=%b%b%b%b exp=1010", in_ready, out_valid, zero, illegal); end
    total++; if ({result, hi, lo, alu_ctrl} !== {96'h0, 5'b0}) begin bad++; $display("FAIL rstmid_regs got=%h %h %h %b exp=0", result, hi, lo, alu_ctrl); end
    @(negedge clk); rst_n = 1'b1;
    drive(2'b00, 6'b100001, 32'd2, 32'd3, 5'd0);
    total++; if ({out_valid, result} !== {1'b1, 32'd5}) begin bad++; $display("FAIL post_rst_add got=v%b %h exp=v1 5", out_valid, result); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk); rst_n = 1'b1;
    test_add_sub;
    test_aluop;
    test_back_to_back;
    test_misc;
    test_mult;
    test_div;
    test_flush;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
